hdr_merge_five: RTL and testbench
=================================

HDR_MERGE_FIVE -- requirements
Module: hdr_merge_five

Interface
REQ-001 Parameter: N, 5, pixel width in bits.
REQ-002 Parameter: WW, 8, weight width in bits.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  input sample set present.
REQ-006 Port: in_ready  output  1  block can accept a sample set.
REQ-007 Port: pixel_high, pixel_mid, pixel_low  input  N each  exposure pixel values.
REQ-008 Port: w_high, w_mid, w_low  input  WW each  per-exposure weights from the weighting stage.
REQ-009 Port: out_valid  output  1  merged result present.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: out_pixel  output  N  merged pixel value.
REQ-012 Port: out_div_zero  output  1  weight sum was zero for this result.

Function
REQ-013 The block SHALL compute out_pixel = floor((w_high*pixel_high + w_mid*pixel_mid + w_low*pixel_low) / (w_high + w_mid + w_low)).
REQ-014 The numerator SHALL be N+WW+2 bits (15 at defaults) and the denominator WW+2 bits (10), with no overflow or truncation.
REQ-015 Division SHALL be iterative restoring, one quotient bit per cycle, N+WW+2 iterations. Only the low N quotient bits SHALL drive out_pixel; the upper bits are provably zero.
REQ-016 The FSM SHALL have four states:
- IDLE: in_ready=1.
- MAC: numerator and denominator registered.
- DIV: iteration counter running.
- DONE: out_valid=1.
REQ-017 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1 (edge E0). All six data inputs SHALL be captured into internal registers and the FSM SHALL enter MAC.
REQ-018 At E1, if the denominator is nonzero, the FSM SHALL register numerator and denominator, clear the counter and enter DIV.
REQ-019 Edges E2..E16 SHALL each perform one iteration. At E16 the FSM SHALL enter DONE and load out_pixel, with out_div_zero=0.
REQ-020 If the denominator is zero, then at E1 the FSM SHALL enter DONE with out_pixel = captured pixel_mid and out_div_zero=1.
REQ-021 in_ready SHALL be 0 in MAC, DIV and DONE. in_valid SHALL be ignored while in_ready=0.
REQ-022 In DONE, out_pixel and out_div_zero SHALL hold stable until out_valid and out_ready are both 1 on an edge. At that edge the FSM SHALL return to IDLE.
REQ-023 No input SHALL be accepted on the same edge as the output handshake. Minimum spacing between accepts SHALL be 18 cycles for the nonzero path and 3 cycles for the zero path.
REQ-024 Input changes after E0 SHALL NOT affect the result in flight.
REQ-025 out_pixel SHALL be registered and SHALL change only on entry to DONE.

Reset
REQ-026 While rst_n=0, regardless of clock:
- FSM=IDLE.
- out_valid=0, out_pixel=0, out_div_zero=0.
- in_ready=1.
- Counter, numerator, denominator and quotient registers = 0.
REQ-027 Reset asserted in any state, including mid-DIV or DONE, SHALL discard the operation in flight.
REQ-028 After rst_n deasserts, the first accept SHALL be possible on the first clock edge.

Verification
REQ-029 Weights 16/16/16 with pixels 10/20/30 -> out_pixel=20, out_div_zero=0, out_valid rises 16 cycles after the accept edge.
REQ-030 Weights 1/16/1 with pixels 31/15/0 -> numerator 271, denominator 18, out_pixel=15.
REQ-031 Weights 0/0/0 with pixel_mid=7 -> out_pixel=7, out_div_zero=1, out_valid 1 cycle after accept.
REQ-032 Weights 255/255/255 with pixels 31/31/31 -> out_pixel=31 (maximum numerator 23715, no overflow).
REQ-033 Backpressure: out_ready held 0 for 5 cycles in DONE, with in_valid=1 and changing inputs throughout. Required: out_pixel stable, in_ready=0 and no new accept until the handshake; in_ready=1 the cycle after the handshake.
REQ-034 Reset pulse at the 8th DIV cycle -> outputs 0 and in_ready=1 immediately. The next sample after release SHALL produce the correct result with no residue from the aborted one.

Source files
------------

// File: rtl/hdr_merge_five.sv
`default_nettype none
// ============================================================================
// Module      : hdr_merge_five
// Description : Weighted merge of three exposure pixels. Computes
//               floor(sum(w*p) / sum(w)) with an iterative restoring
//               divider (one quotient bit per cycle). A zero weight sum
//               bypasses the divider and returns the mid exposure pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module hdr_merge_five #(
  parameter int N  = 5,
  parameter int WW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  pixel_high,
  input  logic [N-1:0]  pixel_mid,
  input  logic [N-1:0]  pixel_low,
  input  logic [WW-1:0] w_high,
  input  logic [WW-1:0] w_mid,
  input  logic [WW-1:0] w_low,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_pixel,
  output logic          out_div_zero
);

  // Numerator holds three N*WW products; denominator holds three weights.
  localparam int c_num_w = N + WW + 2;
  localparam int c_den_w = WW + 2;
  localparam int c_cnt_w = $clog2(c_num_w);
  localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(c_num_w - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [N-1:0]         r_out_pixel;
  logic                 r_div_zero;

  logic [N-1:0]         r_pix_h, r_pix_m, r_pix_l;
  logic [WW-1:0]        r_w_h, r_w_m, r_w_l;

  // r_numq starts as the numerator; quotient bits shift in from the LSB
  // as numerator bits shift out of the MSB.
  logic [c_num_w-1:0]   r_numq;
  logic [c_den_w-1:0]   r_den;
  logic [c_den_w-1:0]   r_rem;
  logic [c_cnt_w-1:0]   r_cnt;

  logic [c_num_w-1:0]   w_num;
  logic [c_den_w-1:0]   w_den;
  logic [c_den_w:0]     w_rem_sh;
  logic [c_den_w:0]     w_diff;
  logic                 w_ge;
  logic [c_den_w-1:0]   w_rem_nx;
  logic [c_num_w-1:0]   w_numq_nx;

  // Weighted sum and weight sum from the captured sample set.
  assign w_num = c_num_w'(r_w_h) * c_num_w'(r_pix_h)
               + c_num_w'(r_w_m) * c_num_w'(r_pix_m)
               + c_num_w'(r_w_l) * c_num_w'(r_pix_l);
  assign w_den = c_den_w'(r_w_h) + c_den_w'(r_w_m) + c_den_w'(r_w_l);

  // One restoring step. The shifted remainder is below 2*den, so the borrow
  // bit of the trial subtraction alone decides the quotient bit.
  assign w_rem_sh  = {r_rem, r_numq[c_num_w-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_den};
  assign w_ge      = ~w_diff[c_den_w];
  assign w_rem_nx  = w_ge ? w_diff[c_den_w-1:0] : w_rem_sh[c_den_w-1:0];
  assign w_numq_nx = {r_numq[c_num_w-2:0], w_ge};

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_pixel    = r_out_pixel;
  assign out_div_zero = r_div_zero;

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_div_zero  <= 1'b0;
      r_pix_h     <= '0;
      r_pix_m     <= '0;
      r_pix_l     <= '0;
      r_w_h       <= '0;
      r_w_m       <= '0;
      r_w_l       <= '0;
      r_numq      <= '0;
      r_den       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_pix_h    <= pixel_high;
            r_pix_m    <= pixel_mid;
            r_pix_l    <= pixel_low;
            r_w_h      <= w_high;
            r_w_m      <= w_mid;
            r_w_l      <= w_low;
            r_in_ready <= 1'b0;
            r_state    <= MAC;
          end
        end
        MAC: begin
          if (w_den == '0) begin
            r_out_pixel <= r_pix_m;
            r_div_zero  <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_numq  <= w_num;
            r_den   <= w_den;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= DIV;
          end
        end
        DIV: begin
          r_numq <= w_numq_nx;
          r_rem  <= w_rem_nx;
          r_cnt  <= r_cnt + c_cnt_w'(1);
          if (r_cnt == c_last_iter) begin
            // Quotient never exceeds the largest pixel, so its upper bits are zero.
            r_out_pixel <= w_numq_nx[N-1:0];
            r_div_zero  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdr_merge_five.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdr_merge_five
// Description : Directed self-checking bench for hdr_merge_five.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdr_merge_five;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] pixel_high, pixel_mid, pixel_low;
  logic [7:0] w_high, w_mid, w_low;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_pixel;
  logic       out_div_zero;

  int checks;
  int errors;

  hdr_merge_five #(.N(5), .WW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pixel_high  (pixel_high),
    .pixel_mid   (pixel_mid),
    .pixel_low   (pixel_low),
    .w_high      (w_high),
    .w_mid       (w_mid),
    .w_low       (w_low),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixel   (out_pixel),
    .out_div_zero(out_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a sample set at the negedge; it is accepted on the next posedge.
  task automatic set_inputs(input logic [4:0] ph, input logic [4:0] pm, input logic [4:0] pl,
                            input logic [7:0] wh, input logic [7:0] wm, input logic [7:0] wl);
    pixel_high = ph; pixel_mid = pm; pixel_low = pl;
    w_high = wh; w_mid = wm; w_low = wl;
  endtask

  // Count edges after the accept edge until out_valid; bounded at 40.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic accept(input logic [4:0] ph, input logic [4:0] pm, input logic [4:0] pl,
                        input logic [7:0] wh, input logic [7:0] wm, input logic [7:0] wl);
    @(negedge clk);
    set_inputs(ph, pm, pl, wh, wm, wl);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_inputs(5'd0, 5'd0, 5'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_pixel !== 5'd0) begin errors++; $display("FAIL reset_out_pixel got=%0d exp=0", out_pixel); end
    checks++; if (out_div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got=%b exp=0", out_div_zero); end
    rst_n = 1'b1;
  endtask

  task automatic test_equal_weights;
    int cyc;
    accept(5'd10, 5'd20, 5'd30, 8'd16, 8'd16, 8'd16);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL eq_busy got=%b exp=0", in_ready); end
    wait_valid(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL eq_latency got=%0d exp=16", cyc); end
    checks++; if (out_pixel !== 5'd20) begin errors++; $display("FAIL eq_pixel got=%0d exp=20", out_pixel); end
    checks++; if (out_div_zero !== 1'b0) begin errors++; $display("FAIL eq_div_zero got=%b exp=0", out_div_zero); end
    handshake();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL eq_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_weighted;
    int cyc;
    // 16*15 + 31 + 0 = 271, 271/18 = 15.06
    accept(5'd31, 5'd15, 5'd0, 8'd1, 8'd16, 8'd1);
    wait_valid(cyc);
    checks++; if (out_pixel !== 5'd15 || cyc != 16) begin
      errors++; $display("FAIL weighted got=%0d lat=%0d exp=15 lat=16", out_pixel, cyc); end
    handshake();
  endtask

  task automatic test_zero_weights;
    int cyc;
    accept(5'd3, 5'd7, 5'd9, 8'd0, 8'd0, 8'd0);
    wait_valid(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL zero_latency got=%0d exp=1", cyc); end
    checks++; if (out_pixel !== 5'd7) begin errors++; $display("FAIL zero_pixel got=%0d exp=7", out_pixel); end
    checks++; if (out_div_zero !== 1'b1) begin errors++; $display("FAIL zero_flag got=%b exp=1", out_div_zero); end
    handshake();
  endtask

  task automatic test_max;
    int cyc;
    // 23715 / 765 = 31
    accept(5'd31, 5'd31, 5'd31, 8'd255, 8'd255, 8'd255);
    wait_valid(cyc);
    checks++; if (out_pixel !== 5'd31 || out_div_zero !== 1'b0) begin
      errors++; $display("FAIL max_pixel got=%0d dz=%b exp=31 dz=0", out_pixel, out_div_zero); end
    handshake();
  endtask

  task automatic test_backpressure;
    int cyc;
    int bad;
    // 27 + 8 + 30 = 65, 65/6 = 10.83
    accept(5'd9, 5'd4, 5'd30, 8'd3, 8'd2, 8'd1);
    wait_valid(cyc);
    checks++; if (out_pixel !== 5'd10 || cyc != 16) begin
      errors++; $display("FAIL bp_pixel got=%0d lat=%0d exp=10 lat=16", out_pixel, cyc); end
    bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_inputs(5'(i + 1), 5'(i * 3), 5'(31 - i), 8'(i * 40), 8'(7 + i), 8'd0);
      @(posedge clk); #1;
      if (out_pixel !== 5'd10 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL bp_hold bad_cycles=%0d exp=0 (pix=%0d rdy=%b vld=%b)", bad, out_pixel, in_ready, out_valid); end
    // in_valid stays high across the handshake edge; it must not be taken.
    handshake();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_no_accept in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    // A: 30 + 60 = 90, 90/15 = 6. B: 3400/200 = 17.
    accept(5'd3, 5'd31, 5'd12, 8'd10, 8'd0, 8'd5);
    set_inputs(5'd1, 5'd17, 5'd2, 8'd0, 8'd200, 8'd0);
    in_valid = 1'b1;
    wait_valid(cyc);
    checks++; if (out_pixel !== 5'd6 || cyc != 16) begin
      errors++; $display("FAIL b2b_first got=%0d lat=%0d exp=6 lat=16", out_pixel, cyc); end
    handshake();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept in_ready got=%b exp=0", in_ready); end
    wait_valid(cyc);
    checks++; if (out_pixel !== 5'd17 || cyc != 16) begin
      errors++; $display("FAIL b2b_second got=%0d lat=%0d exp=17 lat=16", out_pixel, cyc); end
    handshake();
  endtask

  task automatic test_reset_mid_div;
    int cyc;
    accept(5'd20, 5'd25, 5'd30, 8'd9, 8'd4, 8'd2);
    // E1 enters DIV, E2..E9 are the first eight iterations.
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_pixel !== 5'd0 || out_div_zero !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid vld=%b pix=%0d dz=%b rdy=%b exp 0/0/0/1", out_valid, out_pixel, out_div_zero, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    set_inputs(5'd2, 5'd5, 5'd8, 8'd1, 8'd1, 8'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_first_accept in_ready got=%b exp=0", in_ready); end
    wait_valid(cyc);
    checks++; if (out_pixel !== 5'd5 || cyc != 16 || out_div_zero !== 1'b0) begin
      errors++; $display("FAIL rst_next got=%0d lat=%0d dz=%b exp=5 lat=16 dz=0", out_pixel, cyc, out_div_zero); end
    handshake();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_equal_weights();
    test_weighted();
    test_zero_weights();
    test_max();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
